// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU-borrowing multiply sequencer.
// Holds the sequencer state enum, the ALU opcodes it issues and the iteration count.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAdd  = 3'd1,
    StShl  = 3'd2,
    StShr  = 3'd3,
    StDone = 3'd4
  } mul_state_e;

  localparam logic [2:0] ALU_OP_ADD = 3'b100;
  localparam logic [2:0] ALU_OP_SLL = 3'b001;
  localparam logic [2:0] ALU_OP_SRL = 3'b011;

  localparam int unsigned MUL_ITERS = 16;

  // Shifts always move by one bit; the count rides on alu_b[3:0].
  localparam logic [15:0] SHIFT_BY_ONE = 16'd1;

endpackage

// File: rtl/alu_mul_seq_fsm.sv
// Control FSM for alu_mul_seq: state register, next-state logic and iteration counter.
// ALU_MUL_EARLY_TERM_EN: finish as soon as the shifted multiplier reads zero on alu_z.
module alu_mul_seq_fsm
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       alu_z,
  output mul_state_e state,
  output logic [4:0] cnt,
  output logic       accept,
  output logic       finish,
  output logic       ready,
  output logic       done,
  output logic       alu_own
);

  mul_state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       last_iter;

`ifdef ALU_MUL_EARLY_TERM_EN
  // alu_z reflects the multiplier after this shift; zero means no bits left to add.
  assign last_iter = (cnt_q == 5'(MUL_ITERS - 1)) || alu_z;
`else
  logic unused_alu_z;
  assign unused_alu_z = alu_z;
  assign last_iter    = (cnt_q == 5'(MUL_ITERS - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          cnt_d   = 5'd0;
          state_d = StAdd;
        end
      end
      StAdd: state_d = StShl;
      StShl: state_d = StShr;
      StShr: begin
        cnt_d = cnt_q + 5'd1;
        if (last_iter) begin
          finish  = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StAdd;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready   = 1'b0;
    done    = 1'b0;
    alu_own = 1'b0;
    unique case (state_q)
      StIdle:              ready   = 1'b1;
      StAdd, StShl, StShr: alu_own = 1'b1;
      StDone:              done    = 1'b1;
      default:             ready   = 1'b0;
    endcase
  end

  assign state = state_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/alu_mul_seq.sv
// Iterative 16x16->16 unsigned multiplier that borrows the shared ALU for every add and shift.
// ALU_MUL_EARLY_TERM_EN (see alu_mul_seq_fsm) enables early completion on a zero multiplier.
module alu_mul_seq
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        ready,
  output logic        done,
  output logic [15:0] result,
  output logic        alu_own,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_cin,
  output logic        alu_inva,
  output logic        alu_invb,
  output logic        alu_sign,
  input  logic [15:0] alu_out,
  input  logic        alu_z
);

  mul_state_e state;
  logic [4:0] cnt;
  logic       accept;
  logic       finish;

  logic [15:0] prod_q, prod_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [15:0] result_q, result_d;

  alu_mul_seq_fsm u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .alu_z   (alu_z),
    .state   (state),
    .cnt     (cnt),
    .accept  (accept),
    .finish  (finish),
    .ready   (ready),
    .done    (done),
    .alu_own (alu_own)
  );

  // Iteration count is only needed inside the FSM for termination.
  logic [4:0] unused_cnt;
  assign unused_cnt = cnt;

  always_comb begin
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    if (accept) begin
      prod_d   = 16'd0;
      mcand_d  = op_a;
      mplier_d = op_b;
    end
    unique case (state)
      StAdd: prod_d   = alu_out;
      StShl: mcand_d  = alu_out;
      StShr: mplier_d = alu_out;
      default: ;
    endcase
    // prod is final once the last SHR is issued; capture it on the way into DONE.
    if (finish) begin
      result_d = prod_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= 16'd0;
      mcand_q  <= 16'd0;
      mplier_q <= 16'd0;
      result_q <= 16'd0;
    end else begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
    end
  end

  // ALU drive is decoded from state and registers only, so nothing combinational leaks out.
  always_comb begin
    alu_a  = 16'd0;
    alu_b  = 16'd0;
    alu_op = 3'b000;
    unique case (state)
      StAdd: begin
        alu_a  = prod_q;
        alu_b  = mplier_q[0] ? mcand_q : 16'd0;
        alu_op = ALU_OP_ADD;
      end
      StShl: begin
        alu_a  = mcand_q;
        alu_b  = SHIFT_BY_ONE;
        alu_op = ALU_OP_SLL;
      end
      StShr: begin
        alu_a  = mplier_q;
        alu_b  = SHIFT_BY_ONE;
        alu_op = ALU_OP_SRL;
      end
      default: ;
    endcase
  end

  assign result   = result_q;
  assign alu_cin  = 1'b0;
  assign alu_inva = 1'b0;
  assign alu_invb = 1'b0;
  assign alu_sign = 1'b0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a behavioural ALU and a product/latency model.
// Honours ALU_MUL_EARLY_TERM_EN when computing expected latency.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        ready;
  logic        done;
  logic [15:0] result;
  logic        alu_own;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_cin;
  logic        alu_inva;
  logic        alu_invb;
  logic        alu_sign;
  logic [15:0] alu_out;
  logic        alu_z;

  int total = 0;
  int bad   = 0;
  logic [15:0] last_exp = 16'd0;

  alu_mul_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .alu_own  (alu_own),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_cin  (alu_cin),
    .alu_inva (alu_inva),
    .alu_invb (alu_invb),
    .alu_sign (alu_sign),
    .alu_out  (alu_out),
    .alu_z    (alu_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU as seen by the sequencer through the external mux.
  always_comb begin
    alu_out = 16'd0;
    case (alu_op)
      3'b100:  alu_out = alu_a + alu_b;
      3'b001:  alu_out = alu_a << alu_b[3:0];
      3'b011:  alu_out = alu_a >> alu_b[3:0];
      default: alu_out = 16'd0;
    endcase
    alu_z = (alu_out == 16'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int exp_latency(input logic [15:0] b);
`ifdef ALU_MUL_EARLY_TERM_EN
    int k;
    k = 1;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) k = i + 1;
    end
    return 3 * k + 1;
`else
    return 49 + 0 * int'(b[0]);
`endif
  endfunction

  function automatic logic [2:0] exp_op(input int n);
    case ((n - 1) % 3)
      0:       return 3'b100;
      1:       return 3'b001;
      default: return 3'b011;
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_own"}, 32'(alu_own), 32'd0);
    chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit chk_alu,
                        input bit poke, input string tag);
    logic [15:0] exp_r;
    int lat;
    int got;
    exp_r = 16'((32'(a) * 32'(b)) & 32'hFFFF);
    lat   = exp_latency(b);
    got   = 0;
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = 16'($urandom);
    op_b  = 16'($urandom);
    chk({tag, "_held_result"}, 32'(result), 32'(last_exp));
    chk({tag, "_busy"}, 32'(ready), 32'd0);
    for (int n = 1; n <= 60; n++) begin
      if (chk_alu) begin
        chk($sformatf("%s_own_c%0d", tag, n), 32'(alu_own), 32'(n < lat));
        chk($sformatf("%s_op_c%0d", tag, n), 32'(alu_op), 32'(n < lat ? exp_op(n) : 3'b000));
        chk($sformatf("%s_ctl_c%0d", tag, n), 32'({alu_cin, alu_inva, alu_invb, alu_sign}),
            32'd0);
      end
      if (poke && (n == 10 || n == 30)) begin
        chk($sformatf("%s_poke_ready_c%0d", tag, n), 32'(ready), 32'd0);
        chk($sformatf("%s_poke_result_c%0d", tag, n), 32'(result), 32'(last_exp));
        start = 1'b1;
        op_a  = 16'hDEAD;
        op_b  = 16'h0001;
      end
      if (done === 1'b1) begin
        got = n;
        break;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk({tag, "_latency"}, 32'(got), 32'(lat));
    chk({tag, "_result"}, 32'(result), 32'(exp_r));
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_ready_again"}, 32'(ready), 32'd1);
    chk({tag, "_result_hold"}, 32'(result), 32'(exp_r));
    last_exp = exp_r;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = 16'd0;
    op_b  = 16'd0;
    #2;
    check_idle_outputs("reset");
    chk("reset_result", 32'(result), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h0007, 16'h0003, 1'b1, 1'b0, "mul7x3");
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "trunc");
    run_op(16'h1234, 16'h0000, 1'b0, 1'b0, "zero_b");
    run_op(16'h00AB, 16'h8001, 1'b0, 1'b1, "ignore_start");

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1;
    op_a  = 16'h5555;
    op_b  = 16'hF000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #2;
    chk("midop_own", 32'(alu_own), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    chk("async_rst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    last_exp = 16'd0;

    run_op(16'h0010, 16'h0010, 1'b0, 1'b0, "after_rst");

    for (int i = 0; i < 6; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 15);
      run_op(ra, rb, (i == 0), 1'b0, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
